// File: rtl/ex_mem_stage.sv
// Execute stage with operand forwarding and the EX/MEM pipeline register.
// Forwarding prefers the in-flight EX/MEM result over MEM/WB; register 0 is never forwarded.
module ex_mem_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] signextendresult2,
  input  logic [DATA_W-1:0] data21,
  input  logic [DATA_W-1:0] data22,
  input  logic [REG_W-1:0]  rs2,
  input  logic [REG_W-1:0]  rt2,
  input  logic [REG_W-1:0]  rd2,
  input  logic              RegDst2,
  input  logic              Alusrc2,
  input  logic              Memread2,
  input  logic              Memwrite2,
  input  logic              Regwrite2,
  input  logic              Memtoreg2,
  input  logic [1:0]        Aluop2,
  input  logic              wb_regwrite,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              hold,
  input  logic              flush,
  output logic [DATA_W-1:0] aluresult3,
  output logic [DATA_W-1:0] writedata3,
  output logic [REG_W-1:0]  writereg3,
  output logic              zero3,
  output logic              Memread3,
  output logic              Memwrite3,
  output logic              Regwrite3,
  output logic              Memtoreg3
);

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;
  localparam logic [5:0] FnSll = 6'b000000;
  localparam logic [5:0] FnSrl = 6'b000010;

  logic [DATA_W-1:0] op_a, fwd_b, op_b, alu_result;
  logic [REG_W-1:0]  dest_reg;
  logic [5:0]        funct;
  logic [4:0]        shamt;
  logic              exmem_fwd_ok, memwb_fwd_ok;

  assign funct = signextendresult2[5:0];
  assign shamt = signextendresult2[10:6];

  // A load's EX/MEM value is an address, not the loaded data, so it is never forwarded.
  assign exmem_fwd_ok = Regwrite3 && !Memread3 && (writereg3 != '0);
  assign memwb_fwd_ok = wb_regwrite && (wb_rd != '0);

  always_comb begin
    op_a = data21;
    if (exmem_fwd_ok && (writereg3 == rs2)) begin
      op_a = aluresult3;
    end else if (memwb_fwd_ok && (wb_rd == rs2)) begin
      op_a = wb_data;
    end
  end

  always_comb begin
    fwd_b = data22;
    if (exmem_fwd_ok && (writereg3 == rt2)) begin
      fwd_b = aluresult3;
    end else if (memwb_fwd_ok && (wb_rd == rt2)) begin
      fwd_b = wb_data;
    end
  end

  assign op_b     = Alusrc2 ? signextendresult2 : fwd_b;
  assign dest_reg = RegDst2 ? rd2 : rt2;

  always_comb begin
    alu_result = '0;
    unique case (Aluop2)
      2'b00: alu_result = op_a + op_b;
      2'b01: alu_result = op_a - op_b;
      2'b11: alu_result = op_a | op_b;
      2'b10: begin
        case (funct)
          FnAdd:   alu_result = op_a + op_b;
          FnSub:   alu_result = op_a - op_b;
          FnAnd:   alu_result = op_a & op_b;
          FnOr:    alu_result = op_a | op_b;
          FnSlt:   alu_result = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
          FnSll:   alu_result = op_b << shamt;
          FnSrl:   alu_result = op_b >> shamt;
          default: alu_result = '0;
        endcase
      end
      default: alu_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      aluresult3 <= '0;
      writedata3 <= '0;
      writereg3  <= '0;
      zero3      <= 1'b0;
      Memread3   <= 1'b0;
      Memwrite3  <= 1'b0;
      Regwrite3  <= 1'b0;
      Memtoreg3  <= 1'b0;
    end else if (!hold) begin
      aluresult3 <= alu_result;
      writedata3 <= fwd_b;
      writereg3  <= dest_reg;
      zero3      <= (alu_result == '0);
      Memread3   <= Memread2;
      Memwrite3  <= Memwrite2;
      Regwrite3  <= Regwrite2;
      Memtoreg3  <= Memtoreg2;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed plus randomized checks of ex_mem_stage against a behavioural model
// of the EX/MEM register contents.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] signextendresult2, data21, data22, wb_data;
  logic [4:0]  rs2, rt2, rd2, wb_rd;
  logic        RegDst2, Alusrc2, Memread2, Memwrite2, Regwrite2, Memtoreg2;
  logic [1:0]  Aluop2;
  logic        wb_regwrite, hold, flush;
  logic [31:0] aluresult3, writedata3;
  logic [4:0]  writereg3;
  logic        zero3, Memread3, Memwrite3, Regwrite3, Memtoreg3;

  int checks = 0;
  int failures = 0;

  // Model of the pipeline register contents
  logic [31:0] e_alu, e_wd;
  logic [4:0]  e_wr;
  logic        e_zero, e_mr, e_mw, e_rw, e_mtr;

  always #5 clk = ~clk;

  ex_mem_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .signextendresult2(signextendresult2),
    .data21(data21), .data22(data22), .rs2(rs2), .rt2(rt2), .rd2(rd2),
    .RegDst2(RegDst2), .Alusrc2(Alusrc2), .Memread2(Memread2), .Memwrite2(Memwrite2),
    .Regwrite2(Regwrite2), .Memtoreg2(Memtoreg2), .Aluop2(Aluop2),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .hold(hold), .flush(flush), .aluresult3(aluresult3), .writedata3(writedata3),
    .writereg3(writereg3), .zero3(zero3), .Memread3(Memread3), .Memwrite3(Memwrite3),
    .Regwrite3(Regwrite3), .Memtoreg3(Memtoreg3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] operand(input logic [4:0] src, input logic [31:0] rf);
    if (e_rw && !e_mr && e_wr != 0 && e_wr == src) return e_alu;
    if (wb_regwrite && wb_rd != 0 && wb_rd == src) return wb_data;
    return rf;
  endfunction

  function automatic logic [31:0] alu(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] imm);
    int sh;
    sh = int'(imm[10:6]);
    case (op)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd3: return a | b;
      default: case (imm[5:0])
        6'd32: return a + b;
        6'd34: return a - b;
        6'd36: return a & b;
        6'd37: return a | b;
        6'd42: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
        6'd0:  return b << sh;
        6'd2:  return b >> sh;
        default: return 32'd0;
      endcase
    endcase
  endfunction

  // Compute the model's next state from current inputs, clock once, compare everything.
  task automatic step(input string tag);
    logic [31:0] a, b, r;
    a = operand(rs2, data21);
    b = operand(rt2, data22);
    r = alu(Aluop2, a, Alusrc2 ? signextendresult2 : b, signextendresult2);
    @(posedge clk);
    if (!rst_n || flush) begin
      {e_alu, e_wd, e_wr, e_zero, e_mr, e_mw, e_rw, e_mtr} = '0;
    end else if (!hold) begin
      e_alu = r; e_wd = b; e_wr = RegDst2 ? rd2 : rt2; e_zero = (r == 0);
      e_mr = Memread2; e_mw = Memwrite2; e_rw = Regwrite2; e_mtr = Memtoreg2;
    end
    #1;
    chk({tag, ".alu"}, aluresult3, e_alu);
    chk({tag, ".wdata"}, writedata3, e_wd);
    chk({tag, ".wreg"}, {27'd0, writereg3}, {27'd0, e_wr});
    chk({tag, ".ctl"}, {27'd0, zero3, Memread3, Memwrite3, Regwrite3, Memtoreg3},
        {27'd0, e_zero, e_mr, e_mw, e_rw, e_mtr});
  endtask

  task automatic set_op(input logic [1:0] op, input logic [31:0] imm, input logic src,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic dst,
                        input logic rw);
    Aluop2 = op; signextendresult2 = imm; Alusrc2 = src; data21 = d1; data22 = d2;
    rs2 = rs; rt2 = rt; rd2 = rd; RegDst2 = dst; Regwrite2 = rw;
    Memread2 = 1'b0; Memwrite2 = 1'b0; Memtoreg2 = 1'b0;
  endtask

  initial begin
    {e_alu, e_wd, e_wr, e_zero, e_mr, e_mw, e_rw, e_mtr} = '0;
    rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
    wb_regwrite = 1'b1; wb_rd = 5'd1; wb_data = 32'h55;
    set_op(2'd2, 32'h20, 1'b0, 32'd3, 32'd4, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1);
    Memread2 = 1'b1; Memwrite2 = 1'b1; Memtoreg2 = 1'b1;
    step("reset0");
    step("reset1");
    chk("reset_alu_zero", aluresult3, 32'd0);
    wb_regwrite = 1'b0;
    rst_n = 1'b1;

    set_op(2'd2, 32'h20, 1'b0, 32'd5, 32'd7, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1);
    step("radd");
    chk("radd_lit", {aluresult3[26:0], writereg3}, {27'd12, 5'd9});
    chk("radd_zero", {31'd0, zero3}, 32'd0);

    set_op(2'd2, 32'h20, 1'b0, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    step("add_r3");
    set_op(2'd2, 32'h22, 1'b0, 32'd0, 32'd0, 5'd3, 5'd3, 5'd4, 1'b1, 1'b1);
    step("sub_fwd");
    chk("sub_fwd_lit", {aluresult3[30:0], zero3}, {31'd0, 1'b1});

    set_op(2'd2, 32'h20, 1'b0, 32'd10, 32'd10, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
    step("mk_r5");
    set_op(2'd0, 32'd0, 1'b1, 32'd1, 32'd0, 5'd5, 5'd0, 5'd6, 1'b1, 1'b1);
    wb_regwrite = 1'b1; wb_rd = 5'd5; wb_data = 32'd99;
    step("prio");
    chk("prio_lit", aluresult3, 32'd20);

    set_op(2'd0, 32'd0, 1'b1, 32'd7, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    wb_rd = 5'd0;
    step("r0");
    chk("r0_lit", aluresult3, 32'd7);

    set_op(2'd0, 32'd8, 1'b1, 32'h100, 32'd0, 5'd6, 5'd7, 5'd0, 1'b0, 1'b0);
    Memwrite2 = 1'b1; wb_rd = 5'd7; wb_data = 32'hABCD;
    step("store");
    chk("store_lit", {aluresult3, writedata3[15:0], 15'd0, Memwrite3},
        {32'h108, 16'hABCD, 15'd0, 1'b1});

    wb_regwrite = 1'b0; hold = 1'b1;
    set_op(2'd3, 32'hF0, 1'b1, 32'h1, 32'h2, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step("hold");
    chk("hold_lit", aluresult3, 32'h108);
    flush = 1'b1;
    step("flush_hold");
    chk("flush_lit", {aluresult3, 27'd0, writereg3}, 64'd0);
    hold = 1'b0; flush = 1'b0;

    set_op(2'd2, 32'h2A, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd1, 5'd2, 5'd10, 1'b1, 1'b1);
    step("slt");
    chk("slt_lit", aluresult3, 32'd1);
    set_op(2'd2, 32'h100, 1'b0, 32'd0, 32'd1, 5'd1, 5'd2, 5'd11, 1'b1, 1'b1);
    step("sll");
    chk("sll_lit", aluresult3, 32'd16);

    for (int n = 0; n < 2000; n++) begin
      logic [5:0] fn_tab [8];
      fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h3F};
      rst_n = ($urandom_range(63) != 0);
      hold = ($urandom_range(7) == 0);
      flush = ($urandom_range(15) == 0);
      set_op(2'($urandom), {$urandom} & 32'hFFFF_F800 | {21'd0, 5'($urandom),
             fn_tab[$urandom_range(7)]}, 1'($urandom), $urandom, $urandom,
             5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
             1'($urandom), 1'($urandom));
      Memread2 = ($urandom_range(3) == 0); Memwrite2 = 1'($urandom);
      Memtoreg2 = 1'($urandom);
      wb_regwrite = 1'($urandom); wb_rd = 5'($urandom_range(3)); wb_data = $urandom;
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline register.
- Consumes the registered ID/EX outputs (operands, sign-extended immediate, rs/rt/rd, control bits) and resolves data hazards by forwarding from its own EX/MEM register and from MEM/WB.
- Performs the ALU operation and registers the result, store data, destination register and memory/writeback controls for the MEM stage.

Parameters:
- DATA_W, 32, operand/result width.
- REG_W, 5, register-address width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- signextendresult2  input  DATA_W  sign-extended immediate; [5:0]=funct, [10:6]=shamt.
- data21  input  DATA_W  rs register-file value.
- data22  input  DATA_W  rt register-file value.
- rs2  input  REG_W  source register 1.
- rt2  input  REG_W  source register 2 / I-type destination.
- rd2  input  REG_W  R-type destination.
- RegDst2  input  1  1: destination=rd2, 0: destination=rt2.
- Alusrc2  input  1  1: ALU B=immediate, 0: B=forwarded rt.
- Memread2, Memwrite2, Regwrite2, Memtoreg2  input  1 each  controls passed to MEM/WB.
- Aluop2  input  2  ALU operation class.
- wb_regwrite  input  1  MEM/WB write enable.
- wb_rd  input  REG_W  MEM/WB destination.
- wb_data  input  DATA_W  MEM/WB writeback value.
- hold  input  1  downstream stall; freeze EX/MEM register.
- flush  input  1  insert bubble into EX/MEM.
- aluresult3  output  DATA_W  registered ALU result.
- writedata3  output  DATA_W  registered store data (forwarded rt).
- writereg3  output  REG_W  registered destination register.
- zero3  output  1  registered (ALU result == 0).
- Memread3, Memwrite3, Regwrite3, Memtoreg3  output  1 each  registered controls.

Behaviour:
- Reset (rst_n=0 at posedge): every output goes to 0. Reset has priority over all other inputs.
- Update priority at posedge: rst_n low > flush > hold > load.
  - flush=1: all outputs go to 0 (bubble), even if hold=1.
  - hold=1, flush=0: all outputs keep their values.
  - Otherwise: outputs load the values computed this cycle.
- Latency: exactly 1 cycle, ID/EX inputs to EX/MEM outputs.
- Forwarding (combinational, computed separately for A/rs2 and B/rt2):
  - EX/MEM hit: Regwrite3=1, Memread3=0, writereg3!=0 and writereg3==src → use aluresult3.
  - Otherwise MEM/WB hit: wb_regwrite=1, wb_rd!=0 and wb_rd==src → use wb_data.
  - Otherwise use data21 / data22.
  - EX/MEM has priority over MEM/WB when both hit.
  - Register 0 is never forwarded.
  - Load-use hazards are stalled upstream; this block does not detect them.
- Operands: B = Alusrc2 ? signextendresult2 : forwarded rt. writedata3 always takes forwarded rt, regardless of Alusrc2.
- ALU operation select:
  - Aluop 00: add.
  - Aluop 01: sub.
  - Aluop 11: or.
  - Aluop 10: decode funct (signextendresult2[5:0]):
    - 100000 add
    - 100010 sub
    - 100100 and
    - 100101 or
    - 101010 slt (signed; result 1 or 0)
    - 000000 sll (B << shamt)
    - 000010 srl (logical)
    - any other funct: result 0
- Arithmetic: modulo 2^DATA_W; overflow wraps silently, no trap.
- zero3 is registered from the same result as aluresult3.
- Destination: writereg3 = RegDst2 ? rd2 : rt2.
- An upstream bubble (all ID/EX controls 0) propagates as Regwrite3=Memwrite3=Memread3=0; the datapath value is don't-care.
- Reset deasserted mid-operation: the first edge with rst_n=1 loads normally; no pending state survives reset.

Test Plan:
- Reset: rst_n=0 for 2 cycles with nonzero inputs → all outputs 0; release with hold=0 → outputs load on the next edge.
- R-type add, Aluop=10, funct=100000, data21=5, data22=7, RegDst2=1, rd2=9, Regwrite2=1 → next cycle aluresult3=12, writereg3=9, Regwrite3=1, zero3=0.
- Back-to-back dependency: add r3 (result 12), then sub r4=r3-r3 with stale data21=data22=0 → EX/MEM forward gives aluresult3=0, zero3=1.
- Priority and $0:
  - EX/MEM writes r5=20 while wb_rd=5 with wb_data=99 → operand uses 20.
  - wb_rd=0 with wb_regwrite=1 → no forward.
- Store: Aluop=00, Alusrc2=1, imm=8, data21=0x100, rt forwarded from MEM/WB as 0xABCD, Memwrite2=1 → aluresult3=0x108, writedata3=0xABCD.
- Control: hold=1 for 3 cycles → outputs frozen; flush=1 with hold=1 → all outputs 0; slt with -1 vs 1 → aluresult3=1; sll with shamt=4, B=1 → 16.
